// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory arbiter.
//   Size encodings (SZ_*), FSM state type, captured-request payload,
//   bus widths and the default starvation limit.
package mem_pkg;

  localparam int unsigned ADDR_W           = 18;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned LANES            = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request captured at grant time; fetches are stored as aligned word loads.
  typedef struct packed {
    logic              fetch;
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational big-endian lane formatter.
//   size, offset : access size encoding and byte offset within the word
//   wdata        : right-justified store data
//   rdata        : raw RAM word
//   mask, wlane  : store byte-lane enables and lane-replicated store data
//   rfmt         : load result, zero-extended (0 when misaligned)
//   misaligned   : halfword at odd offset or word at nonzero offset
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [LANES-1:0]  mask,
  output logic [DATA_W-1:0] wlane,
  output logic [DATA_W-1:0] rfmt,
  output logic              misaligned
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] rshift;

  // Offset 0 lives in lane 3, so the byte sits (3 - offset) lanes above bit 0.
  assign shamt  = {~offset, 3'b000};
  assign rshift = rdata >> shamt;

  always_comb begin
    mask       = '0;
    wlane      = wdata;
    rfmt       = '0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        mask  = 4'b1000 >> offset;
        wlane = {4{wdata[7:0]}};
        rfmt  = {24'd0, rshift[7:0]};
      end
      SZ_HALF: begin
        misaligned = offset[0];
        wlane      = {2{wdata[15:0]}};
        if (!offset[0]) begin
          mask = offset[1] ? 4'b0011 : 4'b1100;
          rfmt = offset[1] ? {16'd0, rdata[15:0]} : {16'd0, rdata[31:16]};
        end
      end
      default: begin
        // Word; encoding 11 is treated the same way.
        misaligned = (offset != 2'b00);
        if (offset == 2'b00) begin
          mask = 4'b1111;
          rfmt = rdata;
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and load/store ports onto one RAM.
//   clock, reset          : single clock, synchronous active-high reset
//   fetch*                : fetch request/grant, word response (fetchValid/fetchData)
//   data*                 : load/store request/grant, response with error flag
//   ram*                  : RAM address, read strobe, lane write enables, data
// Sequence per access: grant (IDLE/RESP) -> ACCESS (RAM cycle) -> RESP (Valid).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchGrant,
  output logic              fetchValid,
  output logic [DATA_W-1:0] fetchData,
  input  logic              dataReq,
  input  logic              dataWe,
  input  logic [1:0]        dataSize,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataWData,
  output logic              dataGrant,
  output logic              dataValid,
  output logic              dataErr,
  output logic [DATA_W-1:0] dataRData,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              ramIsRead,
  output logic [LANES-1:0]  ramIsWrite,
  output logic [DATA_W-1:0] ramWriteData,
  output logic              ramByteRead,
  input  logic [DATA_W-1:0] ramData
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  state_t            state, state_nxt;
  req_t              cur;
  logic [CNT_W-1:0]  starve_cnt;
  logic [DATA_W-1:0] fetch_data_q, data_rdata_q;
  logic              grant_slot, fetch_win, data_win;
  logic [LANES-1:0]  fmt_mask;
  logic [DATA_W-1:0] fmt_wlane, fmt_rdata;
  logic              fmt_mis;

  assign ramByteRead = 1'b0;

  mem_lane_fmt u_fmt (
    .size       (cur.size),
    .offset     (cur.fetch ? 2'b00 : cur.addr[1:0]),
    .wdata      (cur.wdata),
    .rdata      (ramData),
    .mask       (fmt_mask),
    .wlane      (fmt_wlane),
    .rfmt       (fmt_rdata),
    .misaligned (fmt_mis)
  );

  // Arbitration: data first unless fetch has waited STARVE_LIMIT data grants.
  always_comb begin
    grant_slot = !reset && ((state == IDLE) || (state == RESP));
    fetch_win  = grant_slot && fetchReq && (!dataReq || (starve_cnt == LIMIT_C));
    data_win   = grant_slot && dataReq && !fetch_win;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and RAM/handshake outputs.
  always_comb begin
    state_nxt    = state;
    fetchGrant   = fetch_win;
    dataGrant    = data_win;
    fetchValid   = 1'b0;
    dataValid    = 1'b0;
    dataErr      = 1'b0;
    ramAddress   = '0;
    ramIsRead    = 1'b0;
    ramIsWrite   = '0;
    ramWriteData = '0;
    case (state)
      IDLE: begin
        if (fetch_win || data_win) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt  = RESP;
        ramAddress = {cur.addr[ADDR_W-1:2], 2'b00};
        if (!fmt_mis) begin
          if (cur.we) begin
            ramIsWrite   = fmt_mask;
            ramWriteData = fmt_wlane;
          end else begin
            ramIsRead = 1'b1;
          end
        end
      end
      RESP: begin
        state_nxt  = (fetch_win || data_win) ? ACCESS : IDLE;
        fetchValid = cur.fetch;
        dataValid  = !cur.fetch;
        dataErr    = !cur.fetch && fmt_mis;
      end
      default: state_nxt = IDLE;
    endcase
    // A reset in ACCESS must not reach the RAM.
    if (reset) begin
      fetchValid   = 1'b0;
      dataValid    = 1'b0;
      dataErr      = 1'b0;
      ramAddress   = '0;
      ramIsRead    = 1'b0;
      ramIsWrite   = '0;
      ramWriteData = '0;
    end
  end

  // Response data: live RAM word in RESP, otherwise the last delivered value.
  always_comb begin
    fetchData = fetch_data_q;
    dataRData = data_rdata_q;
    if (state == RESP) begin
      if (cur.fetch) fetchData = ramData;
      else           dataRData = cur.we ? '0 : fmt_rdata;
    end
    if (reset) begin
      fetchData = '0;
      dataRData = '0;
    end
  end

  // Request capture, starvation counter and held response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt   <= '0;
      cur          <= '0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (fetch_win || !fetchReq)
        starve_cnt <= '0;
      else if (data_win && (starve_cnt != LIMIT_C))
        starve_cnt <= starve_cnt + CNT_W'(1);

      if (fetch_win)
        cur <= '{fetch: 1'b1, we: 1'b0, size: SZ_WORD, addr: fetchAddr, wdata: 32'd0};
      else if (data_win)
        cur <= '{fetch: 1'b0, we: dataWe, size: dataSize, addr: dataAddr, wdata: dataWData};

      if (state == RESP) begin
        fetch_data_q <= fetchData;
        data_rdata_q <= dataRData;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data-port grants while fetchReq is pending.
REQ-002 clock  in  1  single clock; all state changes on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 fetchReq  in  1  instruction-fetch request, held until fetchGrant.
REQ-005 fetchAddr  in  18  byte address, word-aligned (bits [1:0] ignored).
REQ-006 fetchGrant  out  1  one-cycle pulse: request captured.
REQ-007 fetchValid  out  1  one-cycle pulse: fetchData valid.
REQ-008 fetchData  out  32  fetched word.
REQ-009 dataReq  in  1  load/store request, held until dataGrant.
REQ-010 dataWe  in  1  1 = store, 0 = load.
REQ-011 dataSize  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-012 dataAddr  in  18  byte address.
REQ-013 dataWData  in  32  store data, right-justified.
REQ-014 dataGrant  out  1  one-cycle pulse: request captured.
REQ-015 dataValid  out  1  one-cycle pulse: load data valid or store complete.
REQ-016 dataErr  out  1  qualifies dataValid: misaligned access, no RAM write performed.
REQ-017 dataRData  out  32  load result, zero-extended.
REQ-018 ramAddress  out  18  to RAM address.
REQ-019 ramIsRead  out  1  to RAM isRead.
REQ-020 ramIsWrite  out  4  to RAM byte-lane write enables.
REQ-021 ramWriteData  out  32  to RAM writeData, lane-aligned.
REQ-022 ramByteRead  out  1  tied to 0.
REQ-023 ramData  in  32  from RAM; valid one cycle after the cycle ramIsRead is high.

Function
REQ-024 The FSM SHALL have states IDLE, ACCESS and RESP; IDLE->ACCESS on grant; ACCESS->RESP always; RESP->ACCESS on a new grant, else RESP->IDLE.
REQ-025 Grants SHALL issue only in IDLE or RESP, at most one per cycle, asserted combinationally in the cycle the request is seen; address, size, we and data are captured at that edge.
REQ-026 Arbitration SHALL give data priority over fetch, except that fetch wins when starveCnt == STARVE_LIMIT.
REQ-027 starveCnt SHALL increment on each data grant made while fetchReq is high, saturate at STARVE_LIMIT, and clear on a fetch grant or when fetchReq is low.
REQ-028 In ACCESS, the block SHALL drive ramAddress from the captured address; for reads it SHALL assert ramIsRead, and for stores ramIsWrite carries the lane mask.
REQ-029 In RESP, the block SHALL pulse the owner's Valid and present the formatted ramData; request-to-Valid latency is 3 cycles, and throughput is one access per 2 cycles.
REQ-030 Lanes SHALL be big-endian: byte offset 0 -> lane 3 (bits 31:24), offset 3 -> lane 0.
REQ-031 Byte store SHALL replicate dataWData[7:0] on all lanes, with mask 1000>>offset.
REQ-032 Halfword store at offset 0 SHALL use mask 1100 and at offset 2 mask 0011, with dataWData[15:0] replicated.
REQ-033 Word store SHALL use mask 1111.
REQ-034 Loads SHALL extract the addressed byte or half into the low bits, zero-extended.
REQ-035 A halfword at an odd offset or a word at a nonzero offset SHALL be misaligned: ramIsWrite = 0000 and ramIsRead = 0, and RESP pulses dataValid with dataErr = 1 and dataRData = 0.
REQ-036 When fetchReq and dataReq rise in the same cycle, data SHALL be granted; fetch SHALL be granted in the following RESP if no data request is pending.
REQ-037 Outputs fetchData and dataRData SHALL be held until the next Valid of the same port.

Reset
REQ-038 During reset the FSM SHALL enter IDLE and starveCnt SHALL be 0; all outputs are 0.
REQ-039 ramIsRead and ramIsWrite SHALL be gated by ~reset so that a reset asserted in ACCESS performs no RAM write.
REQ-040 An access interrupted by reset SHALL produce no Valid and no Grant after reset deasserts.

Structure
REQ-041 Package mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state encoding and the STARVE_LIMIT default.
REQ-042 Sub-module mem_lane_fmt SHALL be combinational: store mask/data alignment, load extraction and misalignment detection.

Verification
REQ-043 Word store at 0x10 with 0xDEADBEEF, then word load at 0x10 -> dataValid 3 cycles after each request, dataRData = 0xDEADBEEF.
REQ-044 Byte store of 0xAB at 0x11, then word load at 0x10 -> 0xDEABBEEF; byte load at 0x11 -> 0x000000AB.
REQ-045 Halfword store at 0x13 -> ramIsWrite stays 0000 and dataValid is accompanied by dataErr = 1; a following word load at 0x10 is unchanged.
REQ-046 fetchReq and dataReq held continuously -> grant order is D, D, D, D, F, D, ...
REQ-047 Simultaneous first requests -> data granted first, fetch granted in the next RESP cycle, and fetchValid carries the RAM word at fetchAddr.
REQ-048 Reset asserted during the ACCESS cycle of a store -> no RAM write, no dataValid, and the FSM is in IDLE after reset deasserts.
